str_frame: RTL
==============

# str_frame

Stream framer that sits directly upstream of the stream gear box. It counts words of a narrow input stream against a runtime-configured frame length and drives `last` on the final word of every frame, so the gear box flushes its wide word on true frame boundaries. Frames repeat at the loaded length until a new length is written. Short and long upstream frames are flagged, and short frames can optionally be zero-padded.

## Interface
- `DATA_WIDTH`, default 8: data word width of both streams.
- `LEN_WIDTH`, default 16: width of the frame-length field and of the word counter.

Reset `rst`, synchronous, active-high; clock `clk`.

- `clk` in 1: clock.
- `rst` in 1: reset.
- `cfg_len` in LEN_WIDTH: frame length in words; 0 means stop.
- `cfg_val` in 1: configuration request.
- `cfg_rdy` out 1: configuration accepted when `cfg_val & cfg_rdy`.
- `up_data` in DATA_WIDTH: input word.
- `up_last` in 1: upstream end-of-frame marker.
- `up_val` in 1: input valid.
- `up_rdy` out 1: input ready.
- `dn_data` out DATA_WIDTH: output word; feeds the gear box.
- `dn_last` out 1: framed end-of-frame marker.
- `dn_val` out 1: output valid.
- `dn_rdy` in 1: output ready.
- `busy` out 1: a frame length is loaded (state not IDLE).
- `err_short` out 1: one-cycle pulse; `up_last` was accepted before the frame count was reached.
- `err_long` out 1: one-cycle pulse; the frame's final word was accepted without `up_last`.

## Operation
- Transfer rules: an up transfer occurs when `up_val & up_rdy`; a down transfer occurs when `dn_val & dn_rdy`.
- Registers:
  - `len_r`: the loaded frame length.
  - `cnt`: words accepted in the current frame, range 0..`len_r`-1.
  - Output register: one entry holding `dn_data`, `dn_last`, `dn_val`.
- States:
  - IDLE: `up_rdy`=0, `cfg_rdy`=1.
    - Accepted `cfg_len`≠0: load `len_r`, clear `cnt`, go to RUN.
    - Accepted `cfg_len`=0: ignored; stay in IDLE.
  - RUN: `up_rdy` = `~dn_val | dn_rdy`. `cfg_rdy` = (`cnt`==0 and no up transfer this cycle).
    - Accepted cfg with nonzero length: reload `len_r`.
    - Accepted cfg with zero length: go to IDLE.
    - Each up transfer loads the output register with `up_data` and increments `cnt`.
    - When `cnt`==`len_r`-1 on that transfer: set `dn_last`=1 and wrap `cnt` to 0. If `up_last`=0 on this transfer, pulse `err_long`; the following upstream words start the next frame.
    - When `up_last`=1 and `cnt`<`len_r`-1: pulse `err_short`, with behaviour per Configuration.
  - PAD (only with the macro): `up_rdy`=0, `cfg_rdy`=0. Emits zero words as the output register frees until `cnt` wraps. The final pad word carries `dn_last`=1, then the block returns to RUN.
- Arithmetic: `cnt` compares against `len_r`-1 in LEN_WIDTH unsigned. `len_r`=1 makes every word last.
- Simultaneous events: a down transfer and an up transfer in the same cycle are allowed; the output register reloads with no bubble. A cfg request is never accepted in the same cycle as an up transfer.
- Reset mid-frame: the partial frame is discarded with no `last` emitted, and the block returns to IDLE.

## Timing
- Reset values: `dn_val`=0, `dn_last`=0, `dn_data`=0, `up_rdy`=0, `cfg_rdy`=1, `busy`=0, `err_short`=0, `err_long`=0. State is IDLE, `cnt`=0, `len_r`=0.
- Latency is 1 cycle from up transfer to `dn_val`.
- Throughput is 1 word/cycle while `dn_rdy`=1.
- `dn_data` and `dn_last` hold stable while `dn_val & ~dn_rdy`.
- `err_*` pulse in the cycle after the offending up transfer, aligned with `dn_val` of that word.
- `busy` rises the cycle after cfg acceptance.
- PAD emits one zero word per cycle with `dn_rdy`=1.

## Configuration
- Macro: `STR_FRAME_PAD_EN`.
- Defined: a short frame's terminating word is emitted with `dn_last`=0. The block enters PAD and appends zero words until the frame reaches `len_r`; the final pad word carries `dn_last`=1.
- Undefined: a short frame's terminating word is emitted with `dn_last`=1, `cnt` clears to 0, and PAD does not exist.
- `err_short` pulses in both builds.

## Test plan
- Load `cfg_len`=4, then stream 8 words 0x01..0x08 with `up_last` on 0x04 and 0x08 and `dn_rdy`=1. Expect out 0x01..0x08 at 1-cycle latency, `dn_last` on 0x04 and 0x08, and no errors.
- `cfg_len`=3 with 3 words, none carrying `up_last`. Expect `dn_last` on word 3 and a single `err_long` pulse.
- `cfg_len`=4 with words 0xA1, 0xA2 and `up_last` on 0xA2.
  - Without macro: expect 0xA1, then 0xA2 with last, plus `err_short`.
  - With macro: expect 0xA1, 0xA2, 0x00, 0x00(last), with `up_rdy`=0 during the two pad cycles.
- `cfg_len`=2 with `dn_rdy` toggled 1,0,0,1 over a 6-word stream. Expect no loss or duplication, data stable while stalled, and `up_rdy` low only while the output register is full and stalled.
- Assert `rst` after the 2nd word of a `cfg_len`=5 frame. Expect all outputs at reset values the next cycle, `busy`=0, and `dn_last` never seen.
- In RUN at `cnt`=0, write `cfg_len`=0. Expect IDLE with `up_rdy`=0 the next cycle; a later `cfg_len`=1 makes every word last.

Source files
------------

// File: rtl/str_frame.sv
// str_frame: counts narrow-stream words against a loaded frame length and
// marks the final word of every frame with dn_last for the gear box.
// Build option STR_FRAME_PAD_EN: zero-pad short frames out to full length.
module str_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  cfg_val,
    output logic                  cfg_rdy,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_last,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic                  dn_last,
    output logic                  dn_val,
    input  logic                  dn_rdy,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_long
);

    typedef enum logic [1:0] {
        IDLE,
        RUN
`ifdef STR_FRAME_PAD_EN
        ,
        PAD
`endif
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 dn_free;
    logic                 up_xfer;
    logic                 cfg_xfer;
    logic                 at_end;

    // The output register can take a new word when empty or draining now.
    assign dn_free  = ~dn_val | dn_rdy;
    assign up_xfer  = up_val & up_rdy;
    assign cfg_xfer = cfg_val & cfg_rdy;
    assign at_end   = (cnt == (len_r - LEN_WIDTH'(1)));
    assign busy     = (state != IDLE);

    // Handshake readies; cfg only lands on a frame boundary with no word moving.
    always_comb begin
        up_rdy  = 1'b0;
        cfg_rdy = 1'b0;
        case (state)
            IDLE: begin
                cfg_rdy = 1'b1;
            end
            RUN: begin
                up_rdy  = dn_free;
                cfg_rdy = (cnt == '0) & ~(up_val & dn_free);
            end
            default: begin
                up_rdy  = 1'b0;
                cfg_rdy = 1'b0;
            end
        endcase
    end

    // Frame FSM with the output register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_r     <= '0;
            cnt       <= '0;
            dn_data   <= '0;
            dn_last   <= 1'b0;
            dn_val    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            if (dn_val & dn_rdy) begin
                dn_val <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cfg_xfer && (cfg_len != '0)) begin
                        len_r <= cfg_len;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cfg_xfer) begin
                        if (cfg_len == '0) begin
                            state <= IDLE;
                        end else begin
                            len_r <= cfg_len;
                        end
                    end
                    if (up_xfer) begin
                        dn_val  <= 1'b1;
                        dn_data <= up_data;
                        if (at_end) begin
                            dn_last  <= 1'b1;
                            cnt      <= '0;
                            err_long <= ~up_last;
                        end else if (up_last) begin
                            err_short <= 1'b1;
`ifdef STR_FRAME_PAD_EN
                            dn_last   <= 1'b0;
                            cnt       <= cnt + LEN_WIDTH'(1);
                            state     <= PAD;
`else
                            dn_last   <= 1'b1;
                            cnt       <= '0;
`endif
                        end else begin
                            dn_last <= 1'b0;
                            cnt     <= cnt + LEN_WIDTH'(1);
                        end
                    end
                end
`ifdef STR_FRAME_PAD_EN
                PAD: begin
                    if (dn_free) begin
                        dn_val  <= 1'b1;
                        dn_data <= '0;
                        if (at_end) begin
                            dn_last <= 1'b1;
                            cnt     <= '0;
                            state   <= RUN;
                        end else begin
                            dn_last <= 1'b0;
                            cnt     <= cnt + LEN_WIDTH'(1);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
